// File: rtl/bike_disp_pkg.sv
// rtl/bike_disp_pkg.sv - shared page, command and FSM definitions for the display navigator
package bike_disp_pkg;
  localparam int NPAGES  = 6;
  localparam int PAGE_W  = 128;
  localparam int OFS_W   = 11;
  localparam int PG_W    = 3;
  localparam int PAGE_SH = $clog2(PAGE_W);

  localparam logic [PG_W-1:0] LAST_PG = PG_W'(NPAGES - 1);
  localparam logic [PG_W-1:0] PG_ONE  = PG_W'(1);

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_L    = 2'b01,
    CMD_R    = 2'b10
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_SETTLE
  } state_t;

  // Neighbouring page with wrap-around, by compare-and-select.
  function automatic logic [PG_W-1:0] page_step(input logic [PG_W-1:0] p, input cmd_t c);
    if (c == CMD_R) return (p == LAST_PG) ? '0 : p + PG_ONE;
    if (c == CMD_L) return (p == '0) ? LAST_PG : p - PG_ONE;
    return p;
  endfunction

  function automatic logic [OFS_W-1:0] page_ofs(input logic [PG_W-1:0] p);
    return OFS_W'(p) << PAGE_SH;
  endfunction
endpackage

// File: rtl/page_nav_sched_if.sv
// rtl/page_nav_sched_if.sv - request/scroller/status bundle of the page navigator
interface page_nav_sched_if;
  import bike_disp_pkg::*;

  logic             btn_l;
  logic             btn_r;
  logic             jump_req;
  logic [PG_W-1:0]  jump_page;
  logic             auto_en;
  logic [OFS_W-1:0] col_offset;
  logic             l_tick;
  logic             r_tick;
  logic [PG_W-1:0]  page;
  logic             busy;
  logic             q_drop;
  logic             err_to;

  modport master (
    output btn_l, btn_r, jump_req, jump_page, auto_en, col_offset,
    input  l_tick, r_tick, page, busy, q_drop, err_to
  );

  modport slave (
    input  btn_l, btn_r, jump_req, jump_page, auto_en, col_offset,
    output l_tick, r_tick, page, busy, q_drop, err_to
  );
endinterface

// File: rtl/nav_cmd_fifo.sv
// rtl/nav_cmd_fifo.sv - synchronous FIFO of 2-bit navigation commands with flush
module nav_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] din,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [1:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout   = mem[rd_ptr[AW-1:0]];
  // A flush with a simultaneous push leaves exactly the new entry in the queue.
  assign wr_idx = flush ? '0 : wr_ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PTR_ONE : '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && (flush || !full)) mem[wr_idx] <= din;
  end
endmodule

// File: rtl/page_nav_sched.sv
// rtl/page_nav_sched.sv - merges button/jump/auto requests and paces single steps to the scroller
module page_nav_sched #(
  parameter int QDEPTH      = 4,
  parameter int SETTLE_CYC  = 400_002,
  parameter int TIMEOUT_CYC = 2**24 - 1,
  parameter int AUTO_CYC    = 250_000_000
) (
  input logic             clk,
  input logic             rst,
  page_nav_sched_if.slave bus
);
  import bike_disp_pkg::*;

  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int AUTO_W  = $clog2(AUTO_CYC) + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [AUTO_W-1:0] AUTO_ONE = AUTO_W'(1);

  state_t            state, state_nxt;
  cmd_t              dir, push_cmd, jdir, jump_dir;
  logic [PG_W-1:0]   page_r, tgt, base, jdist, load_cnt, jump_left, resync_pg;
  logic [CNT_W-1:0]  cnt;
  logic [AUTO_W-1:0] auto_cnt;
  logic [OFS_W-PAGE_SH-1:0] ofs_pg;
  logic push, pop, flush, full, empty, drop, jump_flush, load_set, load_dec;
  logic timeout, at_tgt, busy, auto_fire, user_act, q_drop_r, err_to_r;
  logic [1:0] pop_data;

  nav_cmd_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(push_cmd), .pop(pop), .flush(flush),
    .dout(pop_data), .full(full), .empty(empty)
  );

  assign at_tgt    = (bus.col_offset == page_ofs(tgt));
  assign ofs_pg    = bus.col_offset[OFS_W-1:PAGE_SH];
  assign resync_pg = (ofs_pg > (OFS_W-PAGE_SH)'(NPAGES - 1)) ? LAST_PG : ofs_pg[PG_W-1:0];
  assign busy      = (state != ST_IDLE) || !empty;
  assign user_act  = bus.btn_l || bus.btn_r || bus.jump_req;
  assign auto_fire = bus.auto_en && !busy && !user_act && (auto_cnt == AUTO_W'(AUTO_CYC - 1));
  assign flush     = jump_flush || timeout;

  // Jumps are measured from where the scroller will rest once the in-flight step lands.
  always_comb begin
    base     = (state == ST_IDLE) ? page_r : tgt;
    jdir     = (bus.jump_page >= base) ? CMD_R : CMD_L;
    jdist    = (bus.jump_page >= base) ? bus.jump_page - base : base - bus.jump_page;
    push     = 1'b0;
    push_cmd = CMD_R;
    drop     = 1'b0;
    jump_flush = 1'b0;
    load_set = 1'b0;
    load_cnt = '0;
    load_dec = 1'b0;
    if (bus.jump_req) begin
      if (bus.jump_page > LAST_PG) begin
        drop = 1'b1;
      end else begin
        jump_flush = 1'b1;
        load_set   = 1'b1;
        if (jdist != '0) begin
          push     = 1'b1;
          push_cmd = jdir;
          load_cnt = jdist - PG_ONE;
        end
      end
    end else if (bus.btn_l || bus.btn_r) begin
      if (bus.btn_l != bus.btn_r) begin
        push_cmd = bus.btn_l ? CMD_L : CMD_R;
        push     = !full;
        drop     = full;
      end
    end else if (auto_fire) begin
      push = !full;
      drop = full;
    end else if (jump_left != '0 && !full) begin
      push     = 1'b1;
      push_cmd = jump_dir;
      load_dec = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      ST_IDLE:   if (!empty && !jump_flush) begin
                   pop       = 1'b1;
                   state_nxt = ST_ISSUE;
                 end
      ST_ISSUE:  state_nxt = ST_WAIT;
      ST_WAIT:   if (at_tgt) begin
                   state_nxt = ST_SETTLE;
                 end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                   timeout   = 1'b1;
                   state_nxt = ST_IDLE;
                 end
      ST_SETTLE: if (!at_tgt) state_nxt = ST_WAIT;
                 else if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dir       <= CMD_R;
      tgt       <= '0;
      page_r    <= '0;
      cnt       <= '0;
      auto_cnt  <= '0;
      jump_left <= '0;
      jump_dir  <= CMD_R;
      q_drop_r  <= 1'b0;
      err_to_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      q_drop_r <= drop;
      if (pop) begin
        dir <= cmd_t'(pop_data);
        tgt <= page_step(page_r, cmd_t'(pop_data));
      end
      if (state_nxt != state) cnt <= '0;
      else if (state == ST_WAIT || state == ST_SETTLE) cnt <= cnt + CNT_ONE;
      if (state == ST_WAIT && state_nxt == ST_SETTLE) page_r <= tgt;
      if (timeout) begin
        err_to_r <= 1'b1;
        page_r   <= resync_pg;
      end
      if (load_set) begin
        jump_left <= load_cnt;
        jump_dir  <= jdir;
      end else if (timeout) begin
        jump_left <= '0;
      end else if (load_dec) begin
        jump_left <= jump_left - PG_ONE;
      end
      if (user_act || !bus.auto_en || busy || auto_fire) auto_cnt <= '0;
      else auto_cnt <= auto_cnt + AUTO_ONE;
    end
  end

  assign bus.l_tick = (state == ST_ISSUE) && (dir == CMD_L);
  assign bus.r_tick = (state == ST_ISSUE) && (dir == CMD_R);
  assign bus.page   = page_r;
  assign bus.busy   = busy;
  assign bus.q_drop = q_drop_r;
  assign bus.err_to = err_to_r;
endmodule

// File: tb/tb_page_nav_sched.sv
// tb/tb_page_nav_sched.sv - directed self-checking bench with a behavioural scroller model
module tb_page_nav_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic freeze = 1'b0;
  logic [10:0] ofs, mtgt, frz_ofs, step_ofs;
  logic        moving;
  logic [1:0]  ph;
  int r_cnt = 0, l_cnt = 0, bad_tick = 0;
  int n_tests = 0, n_fail = 0;
  int r0, l0, n;

  page_nav_sched_if nav();

  page_nav_sched #(.QDEPTH(4), .SETTLE_CYC(6), .TIMEOUT_CYC(300), .AUTO_CYC(1000)) dut (
    .clk(clk), .rst(rst), .bus(nav)
  );

  always #5 clk = ~clk;

  // Scroller: 2 columns every 4 cycles toward the next page; wrap moves happen in one cycle.
  assign step_ofs = (mtgt > ofs) ? ofs + 11'd2 : ofs - 11'd2;
  assign nav.col_offset = ofs;

  always @(posedge clk) begin
    if (rst) begin
      ofs <= '0; mtgt <= '0; moving <= 1'b0; ph <= '0;
    end else if (freeze) begin
      ofs <= frz_ofs;
    end else if (nav.r_tick) begin
      if (ofs == 11'd640) ofs <= '0;
      else begin mtgt <= ofs + 11'd128; moving <= 1'b1; ph <= '0; end
    end else if (nav.l_tick) begin
      if (ofs == 11'd0) ofs <= 11'd640;
      else begin mtgt <= ofs - 11'd128; moving <= 1'b1; ph <= '0; end
    end else if (moving) begin
      ph <= ph + 2'd1;
      if (ph == 2'd3) begin
        ofs <= step_ofs;
        if (step_ofs == mtgt) moving <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (nav.r_tick) r_cnt <= r_cnt + 1;
      if (nav.l_tick) l_cnt <= l_cnt + 1;
      if ((nav.r_tick || nav.l_tick) && moving) bad_tick <= bad_tick + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nav.btn_l = 1'b0; nav.btn_r = 1'b0; nav.jump_req = 1'b0; nav.auto_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic l, input logic r);
    nav.btn_l = l; nav.btn_r = r;
    @(negedge clk);
    nav.btn_l = 1'b0; nav.btn_r = 1'b0;
  endtask

  task automatic jump(input logic [2:0] pg);
    nav.jump_req = 1'b1; nav.jump_page = pg;
    @(negedge clk);
    nav.jump_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (nav.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, nav.busy, 0);
  endtask

  initial begin
    nav.btn_l = 1'b0; nav.btn_r = 1'b0; nav.jump_req = 1'b0;
    nav.jump_page = '0; nav.auto_en = 1'b0; frz_ofs = '0;
    repeat (2) @(negedge clk);
    check("rst_page", nav.page, 0);
    check("rst_busy", nav.busy, 0);
    check("rst_ticks", {nav.l_tick, nav.r_tick}, 0);
    check("rst_flags", {nav.q_drop, nav.err_to}, 0);
    rst = 1'b0;

    // Single right step
    press(1'b0, 1'b1);
    check("t1_no_early_tick", nav.r_tick, 0);
    @(negedge clk);
    check("t1_rtick", nav.r_tick, 1);
    wait_idle("t1_idle", 2000);
    check("t1_page", nav.page, 1);
    check("t1_ofs", nav.col_offset, 128);

    // Three queued right steps
    do_reset();
    r0 = r_cnt;
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1);
      @(negedge clk);
    end
    wait_idle("t2_idle", 3000);
    check("t2_rticks", r_cnt - r0, 3);
    check("t2_page", nav.page, 3);
    check("t2_ofs", nav.col_offset, 384);

    // Wrap both ways
    do_reset();
    press(1'b1, 1'b0);
    @(negedge clk);
    check("t3_ltick", nav.l_tick, 1);
    @(negedge clk);
    check("t3_ofs_wrap", nav.col_offset, 640);
    wait_idle("t3_idle_l", 200);
    check("t3_page5", nav.page, 5);
    press(1'b0, 1'b1);
    wait_idle("t3_idle_r", 200);
    check("t3_page0", nav.page, 0);
    check("t3_ofs0", nav.col_offset, 0);

    // Jump flushes queued steps
    do_reset();
    press(1'b0, 1'b1);
    wait_idle("t4_idle_a", 2000);
    r0 = r_cnt;
    nav.btn_r = 1'b1;
    repeat (3) @(negedge clk);
    nav.btn_r = 1'b0;
    jump(3'd4);
    wait_idle("t4_idle_b", 4000);
    check("t4_rticks", r_cnt - r0, 3);
    check("t4_page", nav.page, 4);
    r0 = r_cnt; l0 = l_cnt;
    jump(3'd7);
    check("t4_bad_jump_drop", nav.q_drop, 1);
    repeat (10) @(negedge clk);
    check("t4_bad_jump_busy", nav.busy, 0);
    jump(3'd4);
    check("t4_same_page_drop", nav.q_drop, 0);
    repeat (10) @(negedge clk);
    check("t4_no_ticks", r_cnt + l_cnt, r0 + l0);
    check("t4_same_page_busy", nav.busy, 0);
    do_reset();
    r0 = r_cnt;
    jump(3'd5);
    wait_idle("t4_idle_c", 4000);
    check("t4_long_jump_rticks", r_cnt - r0, 5);
    check("t4_long_jump_page", nav.page, 5);
    r0 = r_cnt; l0 = l_cnt;
    jump(3'd1);
    wait_idle("t4_idle_d", 4000);
    check("t4_left_jump_lticks", l_cnt - l0, 4);
    check("t4_left_jump_page", nav.page, 1);

    // Button cancel and queue overflow
    do_reset();
    r0 = r_cnt; l0 = l_cnt;
    press(1'b1, 1'b1);
    check("t5_cancel_drop", nav.q_drop, 0);
    repeat (3) @(negedge clk);
    check("t5_cancel_busy", nav.busy, 0);
    check("t5_cancel_ticks", r_cnt + l_cnt, r0 + l0);
    press(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      nav.btn_r = 1'b1;
      @(negedge clk);
      check($sformatf("t5_qdrop_%0d", i), nav.q_drop, (i == 4) ? 1 : 0);
    end
    nav.btn_r = 1'b0;
    wait_idle("t5_idle", 3000);
    check("t5_rticks", r_cnt - r0, 5);
    check("t5_page", nav.page, 5);

    // Frozen scroller times out and resyncs
    do_reset();
    freeze = 1'b1; frz_ofs = 11'd258;
    @(negedge clk);
    press(1'b0, 1'b1);
    repeat (100) @(negedge clk);
    check("t6_err_early", nav.err_to, 0);
    wait_idle("t6_idle", 400);
    check("t6_err_to", nav.err_to, 1);
    check("t6_page_resync", nav.page, 2);
    freeze = 1'b0;
    do_reset();
    check("t6_err_cleared", nav.err_to, 0);

    // Auto-rotate
    nav.auto_en = 1'b1;
    n = 0;
    while (!nav.r_tick && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("t7_auto_latency", n, 1001);
    nav.auto_en = 1'b0;
    wait_idle("t7_idle", 2000);
    check("t7_page", nav.page, 1);

    // Reset in the middle of a step
    do_reset();
    press(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t8_rst_outs", {nav.busy, nav.l_tick, nav.r_tick, nav.q_drop, nav.err_to}, 0);
    check("t8_rst_page", nav.page, 0);
    check("t8_rst_ofs", nav.col_offset, 0);
    rst = 1'b0;
    r0 = r_cnt; l0 = l_cnt;
    repeat (5) @(negedge clk);
    check("t8_no_tick", r_cnt + l_cnt, r0 + l0);
    check("t8_busy", nav.busy, 0);

    check("one_step_outstanding", bad_tick, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
